vvm_phase_avg: RTL and testbench
================================

Name: vvm_phase_avg

Overview:
- Post-CORDIC stage of the vvm_dsp chain.
- Consumes the serialized per-channel magnitude/phase stream (one word per channel per CIC output frame, channel 0 = reference).
- Computes each channel's phase relative to channel 0 with modular wrap.
- Smooths magnitude and phase per channel with a wrap-safe first-order IIR set by iir_shift; emits a serialized smoothed stream for the register bank.

Parameters:
- N_CH, 4, channels per frame (power of 2, 2..8).
- W_MAG, 21, unsigned magnitude width.
- W_PH, 21, signed phase width; full scale 2^W_PH = 2*pi.
- F, 16, IIR fractional bits.

Ports:
- sample_clk  in  1  ADC sample clock; all logic on rising edge.
- sample_rst_n  in  1  synchronous, active-low reset.
- in_strobe  in  1  input word valid.
- in_first  in  1  qualifies in_strobe; marks the channel-0 word.
- mag_in  in  W_MAG  magnitude, unsigned.
- phase_in  in  W_PH  phase, signed, modular.
- iir_shift  in  4  smoothing factor 0..15; 0 = no smoothing.
- out_strobe  out  1  output word valid.
- out_ch  out  $clog2(N_CH)  channel index of the output word.
- mag_out  out  W_MAG  smoothed magnitude.
- phase_out  out  W_PH  smoothed (relative) phase.
- frame_done  out  1  pulses with out_strobe of channel N_CH-1.
- err_cnt  out  8  saturating framing-error count.

Behaviour:
- Reset (sample_rst_n=0 at a clock edge):
  - All outputs 0; sequencer goes to WAIT_FIRST.
  - Per-channel seeded flags cleared; reference phase 0.
  - Reset mid-frame abandons the frame; no partial output.
- Sequencer states:
  - WAIT_FIRST: strobes without in_first are dropped (no error). A strobe with in_first accepts the word as ch0 and goes to IN_FRAME, ch=1.
  - IN_FRAME, strobe without in_first: accept as channel ch, ch++. After accepting ch N_CH-1, go to WAIT_FIRST.
  - IN_FRAME, strobe with in_first: framing error. err_cnt++ (saturates at 255). The word is accepted as ch0 of a new frame, ch=1.
  - WAIT_FIRST after a complete frame: a non-first strobe is dropped and counts as an error.
- Relative phase:
  - On ch0 the reference register latches phase_in.
  - ch0 outputs its absolute phase.
  - ch k>0 uses d = phase_in - ref, computed mod 2^W_PH (natural wrap, no saturation).
- IIR, one accumulator pair per channel stored in registers or an N_CH-deep array:
  - Phase: acc_p is W_PH+F bits, modular. err = (d<<F) - acc_p, taken mod 2^(W_PH+F) as signed. acc_p += err>>>iir_shift. This is wrap-safe: the filter takes the short way around the circle.
  - Magnitude: acc_m is W_MAG+F bits, unsigned. err is signed, W_MAG+F+1 bits. acc_m += err>>>iir_shift; no overflow is possible.
  - The first sample of a channel after reset loads acc = x<<F directly (seed) and sets the seeded flag.
  - Outputs = acc>>F (truncation, floor).
  - iir_shift is sampled per word; a change takes effect on the next accepted word.
- Latency:
  - Accepted word at edge n gives out_strobe at edge n+2, with out_ch equal to that word's channel. out_strobe is high for exactly 1 cycle per accepted word.
  - Back-to-back strobes on consecutive cycles are supported at full rate; there is no backpressure.
  - Dropped words produce no output.
- frame_done is asserted in the same cycle as out_strobe for ch N_CH-1.

Optional Feature:
- Macro: VVM_PHASE_DIFF_EN.
- Defined: relative phase as above.
- Undefined: ch k>0 phase is absolute (d = phase_in); the reference register and subtractor are omitted. Sequencing and IIR are unchanged.

Test Plan:
- Pass-through: iir_shift=0, frame ch0..3 mags {1000,2000,3000,4000}, phases {100,600,-200,0} -> 2 cycles after each word, out_ch 0..3, mag_out same values, phase_out {100,500,-300,-100}; frame_done with ch3.
- Wrap subtraction: ch0=1048570, ch1=-1048570 -> ch1 phase_out=12, not -2097140.
- IIR step: seed with mag 0, iir_shift=4, then next frame mag 1600 -> mag_out=100; following frame -> 193 (floor of 100+1500/16).
- Wrap IIR: ch1 seeded 1048500, iir_shift=4, next input -1048500 -> phase_out=1048509 (moves +9.5, floored), never toward 0.
- Framing: in_first on the 2nd word of a frame -> err_cnt=1; that word is output as out_ch=0. Stray non-first strobe in WAIT_FIRST after a full frame -> err_cnt=2, no out_strobe. 300 errors -> err_cnt=255.
- Reset mid-frame: sample_rst_n low for 1 cycle after ch1 -> no further out_strobe until a new in_first; the next word re-seeds (output equals input even with iir_shift=4).

Source files
------------

// File: rtl/vvm_phase_avg.sv
// Per-channel phase referencing and wrap-safe first-order IIR smoothing of the serialized CORDIC stream.
// Optional macro VVM_PHASE_DIFF_EN: when defined, channels k>0 report phase relative to channel 0.
module vvm_phase_avg #(
    parameter int N_CH  = 4,
    parameter int W_MAG = 21,
    parameter int W_PH  = 21,
    parameter int F     = 16,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic                   sample_clk,
    input  logic                   sample_rst_n,
    input  logic                   in_strobe,
    input  logic                   in_first,
    input  logic [W_MAG-1:0]       mag_in,
    input  logic [W_PH-1:0]        phase_in,
    input  logic [3:0]             iir_shift,
    output logic                   out_strobe,
    output logic [CW-1:0]          out_ch,
    output logic [W_MAG-1:0]       mag_out,
    output logic [W_PH-1:0]        phase_out,
    output logic                   frame_done,
    output logic [7:0]             err_cnt
);

    localparam int AW_M = W_MAG + F;
    localparam int AW_P = W_PH + F;

    typedef enum logic [1:0] {
        S_WAIT_FIRST,
        S_IN_FRAME,
        S_FRAME_END
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   ch_reg;
    logic            accept;
    logic [CW-1:0]   acc_ch;
    logic            err_inc;
    logic [W_PH-1:0] ph_d;

    // ---------------- sequencer ----------------
    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n) begin
            state_reg <= S_WAIT_FIRST;
            ch_reg    <= '0;
            err_cnt   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept)
                ch_reg <= acc_ch + CW'(1);
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (accept)
            state_next = (acc_ch == CW'(N_CH - 1)) ? S_FRAME_END : S_IN_FRAME;
    end

    // S_FRAME_END differs from S_WAIT_FIRST only in that a stray word is an error
    always_comb begin
        accept  = 1'b0;
        acc_ch  = '0;
        err_inc = 1'b0;
        case (state_reg)
            S_WAIT_FIRST: begin
                if (in_strobe && in_first)
                    accept = 1'b1;
            end
            S_IN_FRAME: begin
                if (in_strobe) begin
                    accept = 1'b1;
                    if (in_first)
                        err_inc = 1'b1;
                    else
                        acc_ch = ch_reg;
                end
            end
            S_FRAME_END: begin
                if (in_strobe) begin
                    if (in_first)
                        accept = 1'b1;
                    else
                        err_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- phase reference ----------------
`ifdef VVM_PHASE_DIFF_EN
    logic [W_PH-1:0] ref_reg;

    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n)
            ref_reg <= '0;
        else if (accept && in_first)
            ref_reg <= phase_in;
    end

    assign ph_d = in_first ? phase_in : phase_in - ref_reg;
`else
    assign ph_d = phase_in;
`endif

    // ---------------- stage 1: captured word ----------------
    logic             s1_valid_reg;
    logic [CW-1:0]    s1_ch_reg;
    logic [W_MAG-1:0] s1_mag_reg;
    logic [W_PH-1:0]  s1_ph_reg;
    logic [3:0]       s1_shift_reg;

    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_ch_reg    <= '0;
            s1_mag_reg   <= '0;
            s1_ph_reg    <= '0;
            s1_shift_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_ch_reg    <= acc_ch;
                s1_mag_reg   <= mag_in;
                s1_ph_reg    <= ph_d;
                s1_shift_reg <= iir_shift;
            end
        end
    end

    // ---------------- IIR update ----------------
    logic [AW_M-1:0]        acc_m [N_CH];
    logic [AW_P-1:0]        acc_p [N_CH];
    logic [N_CH-1:0]        seeded_reg;
    logic [AW_M-1:0]        acc_m_cur, x_m, acc_m_next;
    logic [AW_P-1:0]        acc_p_cur, x_p, acc_p_next;
    logic signed [AW_M:0]   err_m, step_m;
    logic signed [AW_P-1:0] err_p, step_p;

    // Phase error is taken modulo the full circle, so the filter always turns the short way
    always_comb begin
        acc_m_cur = acc_m[s1_ch_reg];
        acc_p_cur = acc_p[s1_ch_reg];
        x_m       = {s1_mag_reg, {F{1'b0}}};
        x_p       = {s1_ph_reg, {F{1'b0}}};
        err_m     = $signed({1'b0, x_m}) - $signed({1'b0, acc_m_cur});
        step_m    = err_m >>> s1_shift_reg;
        err_p     = $signed(x_p - acc_p_cur);
        step_p    = err_p >>> s1_shift_reg;
        if (seeded_reg[s1_ch_reg]) begin
            acc_m_next = acc_m_cur + step_m[AW_M-1:0];
            acc_p_next = acc_p_cur + step_p;
        end else begin
            acc_m_next = x_m;
            acc_p_next = x_p;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n) begin
            seeded_reg <= '0;
            for (int i = 0; i < N_CH; i++) begin
                acc_m[i] <= '0;
                acc_p[i] <= '0;
            end
        end else if (s1_valid_reg) begin
            acc_m[s1_ch_reg]      <= acc_m_next;
            acc_p[s1_ch_reg]      <= acc_p_next;
            seeded_reg[s1_ch_reg] <= 1'b1;
        end
    end

    // ---------------- stage 2 and output register ----------------
    logic             s2_valid_reg;
    logic [CW-1:0]    s2_ch_reg;
    logic [W_MAG-1:0] s2_mag_reg;
    logic [W_PH-1:0]  s2_ph_reg;

    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_ch_reg    <= '0;
            s2_mag_reg   <= '0;
            s2_ph_reg    <= '0;
            out_strobe   <= 1'b0;
            out_ch       <= '0;
            mag_out      <= '0;
            phase_out    <= '0;
            frame_done   <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_ch_reg  <= s1_ch_reg;
                s2_mag_reg <= acc_m_next[AW_M-1:F];
                s2_ph_reg  <= acc_p_next[AW_P-1:F];
            end
            out_strobe <= s2_valid_reg;
            frame_done <= s2_valid_reg && (s2_ch_reg == CW'(N_CH - 1));
            if (s2_valid_reg) begin
                out_ch    <= s2_ch_reg;
                mag_out   <= s2_mag_reg;
                phase_out <= s2_ph_reg;
            end
        end
    end

endmodule

// File: tb/tb_vvm_phase_avg.sv
// Scoreboard bench for vvm_phase_avg: table-driven frames plus framing, reset and saturation sequences.
module tb_vvm_phase_avg;

`ifdef VVM_PHASE_DIFF_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        sample_clk   = 1'b0;
    logic        sample_rst_n = 1'b0;
    logic        in_strobe    = 1'b0;
    logic        in_first     = 1'b0;
    logic [20:0] mag_in       = '0;
    logic [20:0] phase_in     = '0;
    logic [3:0]  iir_shift    = '0;
    logic        out_strobe;
    logic [1:0]  out_ch;
    logic [20:0] mag_out;
    logic [20:0] phase_out;
    logic        frame_done;
    logic [7:0]  err_cnt;

    vvm_phase_avg dut (
        .sample_clk   (sample_clk),
        .sample_rst_n (sample_rst_n),
        .in_strobe    (in_strobe),
        .in_first     (in_first),
        .mag_in       (mag_in),
        .phase_in     (phase_in),
        .iir_shift    (iir_shift),
        .out_strobe   (out_strobe),
        .out_ch       (out_ch),
        .mag_out      (mag_out),
        .phase_out    (phase_out),
        .frame_done   (frame_done),
        .err_cnt      (err_cnt)
    );

    always #5 sample_clk = ~sample_clk;

    typedef struct {
        int ch;
        int mag;
        int ph;
        bit done;
    } exp_t;

    typedef struct {
        bit first;
        int mag;
        int ph;
        int sh;
        int ech;
        int emag;
        int erel;
        int eabs;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: every out_strobe must match the head of the scoreboard
    always @(negedge sample_clk) begin
        exp_t e;
        if (frame_done === 1'b1 && out_strobe !== 1'b1)
            chk("frame_done_without_strobe", 1, 0);
        if (out_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_strobe_ch", int'(out_ch), -1);
            end else begin
                e = sb.pop_front();
                $display("out ch=%0d mag=%0d ph=%0d done=%0d", out_ch, mag_out,
                         $signed(phase_out), frame_done);
                chk("out_ch", int'(out_ch), e.ch);
                chk("mag_out", int'(mag_out), e.mag);
                chk("phase_out", int'($signed(phase_out)), e.ph);
                chk("frame_done", int'(frame_done), int'(e.done));
            end
        end
    end

    task automatic put(input bit first, input int mag, input int ph, input int sh,
                       input bit expect_out, input int ech, input int emag, input int eph);
        exp_t e;
        @(negedge sample_clk);
        in_strobe = 1'b1;
        in_first  = first;
        mag_in    = 21'(mag);
        phase_in  = 21'(ph);
        iir_shift = 4'(sh);
        if (expect_out) begin
            e.ch   = ech;
            e.mag  = emag;
            e.ph   = eph;
            e.done = (ech == 3);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sample_clk);
            in_strobe = 1'b0;
            in_first  = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(negedge sample_clk);
        chk(name, sb.size(), 0);
    endtask

    vec_t vecs[20];

    initial begin
        // pass-through, shift 0
        vecs[0]  = '{1, 1000, 100, 0, 0, 1000, 100, 100};
        vecs[1]  = '{0, 2000, 600, 0, 1, 2000, 500, 600};
        vecs[2]  = '{0, 3000, -200, 0, 2, 3000, -300, -200};
        vecs[3]  = '{0, 4000, 0, 0, 3, 4000, -100, 0};
        // wrap-around subtraction
        vecs[4]  = '{1, 5, 1048570, 0, 0, 5, 1048570, 1048570};
        vecs[5]  = '{0, 6, -1048570, 0, 1, 6, 12, -1048570};
        vecs[6]  = '{0, 7, 1048570, 0, 2, 7, 0, 1048570};
        vecs[7]  = '{0, 8, 0, 0, 3, 8, -1048570, 0};
        // load known accumulator values
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1048500, 0, 1, 0, 1048500, 1048500};
        vecs[10] = '{0, 0, 0, 0, 2, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 3, 0, 0, 0};
        // IIR, shift 4, first step (ch1 crosses the +/-pi boundary)
        vecs[12] = '{1, 1600, 0, 4, 0, 100, 0, 0};
        vecs[13] = '{0, 1600, -1048500, 4, 1, 100, 1048509, 1048509};
        vecs[14] = '{0, 16, 160, 4, 2, 1, 10, 10};
        vecs[15] = '{0, 0, -32, 4, 3, 0, -2, -2};
        // IIR, second step
        vecs[16] = '{1, 1600, 0, 4, 0, 193, 0, 0};
        vecs[17] = '{0, 1600, -1048500, 4, 1, 193, 1048518, 1048518};
        vecs[18] = '{0, 16, 160, 4, 2, 1, 19, 19};
        vecs[19] = '{0, 0, -32, 4, 3, 0, -4, -4};

        repeat (3) @(negedge sample_clk);
        chk("reset_out_strobe", int'(out_strobe), 0);
        chk("reset_mag_out", int'(mag_out), 0);
        chk("reset_phase_out", int'(phase_out), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        sample_rst_n = 1'b1;

        // Stray words before any frame are dropped silently
        put(0, 9, 9, 0, 0, 0, 0, 0);
        idle(4);
        chk("pre_frame_stray_err_cnt", int'(err_cnt), 0);

        // Table: back-to-back words at full rate
        for (int i = 0; i < 20; i++)
            put(vecs[i].first, vecs[i].mag, vecs[i].ph, vecs[i].sh, 1'b1,
                vecs[i].ech, vecs[i].emag, REL ? vecs[i].erel : vecs[i].eabs);
        idle(1);
        drain("table_drained");
        chk("table_err_cnt", int'(err_cnt), 0);

        // Framing error: second word carries in_first
        put(1, 11, 50, 0, 1, 0, 11, 50);
        put(1, 12, 70, 0, 1, 0, 12, 70);
        put(0, 13, 80, 0, 1, 1, 13, REL ? 10 : 80);
        put(0, 14, 90, 0, 1, 2, 14, REL ? 20 : 90);
        put(0, 15, 100, 0, 1, 3, 15, REL ? 30 : 100);
        idle(4);
        chk("framing_err_cnt", int'(err_cnt), 1);
        put(0, 16, 110, 0, 0, 0, 0, 0);
        idle(4);
        chk("stray_err_cnt", int'(err_cnt), 2);
        drain("framing_drained");

        // Reset mid-frame: nothing from the abandoned frame may come out
        put(1, 500, 7, 4, 0, 0, 0, 0);
        put(0, 600, 8, 4, 0, 0, 0, 0);
        @(negedge sample_clk);
        in_strobe    = 1'b0;
        in_first     = 1'b0;
        sample_rst_n = 1'b0;
        @(negedge sample_clk);
        sample_rst_n = 1'b1;
        chk("midreset_err_cnt", int'(err_cnt), 0);
        chk("midreset_mag_out", int'(mag_out), 0);
        put(0, 1, 1, 4, 0, 0, 0, 0);
        put(0, 2, 2, 4, 0, 0, 0, 0);
        idle(5);
        chk("post_reset_stray_err_cnt", int'(err_cnt), 0);
        put(1, 300, 40, 4, 1, 0, 300, 40);
        put(0, 301, 45, 4, 1, 1, 301, REL ? 5 : 45);
        put(0, 302, 30, 4, 1, 2, 302, REL ? -10 : 30);
        put(0, 303, 40, 4, 1, 3, 303, REL ? 0 : 40);
        idle(1);
        drain("reseed_drained");

        // Error counter saturation with stray words after a complete frame
        for (int i = 0; i < 254; i++)
            put(0, i, i, 0, 0, 0, 0, 0);
        idle(3);
        chk("err_cnt_254", int'(err_cnt), 254);
        put(0, 1, 1, 0, 0, 0, 0, 0);
        idle(3);
        chk("err_cnt_255", int'(err_cnt), 255);
        for (int i = 0; i < 45; i++)
            put(0, i, i, 0, 0, 0, 0, 0);
        idle(3);
        chk("err_cnt_saturated", int'(err_cnt), 255);
        idle(5);
        chk("final_queue_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
